// File: rtl/hd_elastic_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : hd_elastic_buffer_if
// Description : Valid/ready handshake bundle for hd_elastic_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface hd_elastic_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_src;
  logic                  valid;
  logic                  ready_output;
  logic                  valid_output;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_dest;

  // Master drives the upstream beat and the downstream ready
  modport master (
    output data_src, valid, ready,
    input  ready_output, valid_output, data_dest
  );

  modport slave (
    input  data_src, valid, ready,
    output ready_output, valid_output, data_dest
  );
endinterface
`default_nettype wire

// File: rtl/hd_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module      : hd_elastic_buffer
// Description : DEPTH-entry ring elastic buffer with optional zero-latency
//               bypass; port level exists with HD_ELASTIC_BUFFER_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hd_elastic_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int BYPASS     = 1
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  hd_elastic_buffer_if.slave              bus
`ifdef HD_ELASTIC_BUFFER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]      level
`endif
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic w_byp_en;
  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_byp_en = 1'b1;
    end else begin : g_registered
      assign w_byp_en = 1'b0;
    end
  endgenerate

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_CNT_W'(DEPTH));

  // ready_output depends on stored state only, never on ready/valid
  assign bus.ready_output = !w_full;
  assign bus.valid_output = !w_empty || (w_byp_en && bus.valid);
  assign bus.data_dest    = !w_empty ? r_mem[r_rd_ptr]
                          : (w_byp_en ? bus.data_src : '0);

  // A beat only bypasses when nothing is stored, which keeps ordering intact
  assign w_bypass = w_byp_en && w_empty && bus.valid && bus.ready;
  assign w_push   = bus.valid && !w_full && !w_bypass;
  assign w_pop    = !w_empty && bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.data_src;
    end
  end

`ifdef HD_ELASTIC_BUFFER_LEVEL_EN
  assign level = r_count;
`endif

endmodule
`default_nettype wire

// File: doc/hd_elastic_buffer.md
HD_ELASTIC_BUFFER -- requirements
Module: hd_elastic_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits, >=1.
REQ-002 Parameter DEPTH, default 4: storage entries, >=2; non-power-of-2 values SHALL be supported.
REQ-003 Parameter BYPASS, default 1: 1 = zero-latency pass-through when empty; 0 = every beat registered (latency >=1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 data_src  input  DATA_WIDTH  upstream payload.
REQ-007 valid  input  1  upstream valid.
REQ-008 ready_output  output  1  ready to upstream.
REQ-009 valid_output  output  1  valid to downstream.
REQ-010 ready  input  1  downstream ready.
REQ-011 data_dest  output  DATA_WIDTH  downstream payload.
REQ-012 level  output  $clog2(DEPTH+1)  stored-entry count; present only with HD_ELASTIC_BUFFER_LEVEL_EN.

Function
REQ-013 Upstream beat accepted iff valid && ready_output; downstream beat delivered iff valid_output && ready.
REQ-014 Storage: DEPTH-entry ring, write pointer, read pointer, count 0..DEPTH; pointers wrap DEPTH-1 -> 0.
REQ-015 ready_output = (count < DEPTH), a function of registered state only; no combinational path from ready or valid.
REQ-016 valid_output = (count > 0) || (BYPASS && valid).
REQ-017 data_dest = mem[rd_ptr] when count > 0; else data_src when BYPASS=1; else all-zero.
REQ-018 Bypass (BYPASS=1): count==0, valid, ready in same cycle -> beat passes combinationally, nothing stored, count stays 0.
REQ-019 Push: accepted beat not bypassed -> written at wr_ptr, wr_ptr advances, next edge.
REQ-020 Pop: delivered beat with count > 0 -> rd_ptr advances, next edge.
REQ-021 Simultaneous push and pop: both pointers advance, count unchanged.
REQ-022 Ordering: when count > 0, a new upstream beat is always stored, never bypassed; output order = input order.
REQ-023 Full (count==DEPTH): ready_output low; a pop that cycle raises ready_output on the next edge, not the same cycle.
REQ-024 Empty, BYPASS=0: valid_output low; a beat pushed at edge N appears at data_dest with valid_output high after edge N.
REQ-025 Once valid_output is high from stored data, it and data_dest SHALL hold until the beat is delivered.
REQ-026 Throughput: sustained one beat/cycle with ready held high, any DEPTH, both BYPASS modes.

Reset
REQ-027 rst high asynchronously clears count, rd_ptr, wr_ptr to 0 and level to 0.
REQ-028 During and after reset: ready_output = 1; valid_output = BYPASS && valid; storage contents not reset.
REQ-029 Reset mid-operation discards all stored beats; no stale beat is presented after release.

Configuration
REQ-030 Macro HD_ELASTIC_BUFFER_LEVEL_EN defined: port level present, level = count, registered, updated on the same edge as count.
REQ-031 Macro undefined: port level absent; all other behaviour identical.

Verification
REQ-032 BYPASS=1, DEPTH=4, ready=1, push 0x11,0x22,0x33 on consecutive cycles -> same values on data_dest in the same cycles, count stays 0.
REQ-033 DEPTH=4, ready=0, push 0xA0..0xA5 -> ready_output drops after 4th accept, level=4, 0xA4 held; raise ready -> outputs 0xA0,0xA1,0xA2,0xA3,0xA4,0xA5 in order.
REQ-034 DEPTH=3, 10 beats with ready toggling 1,0,1,0 -> all 10 beats delivered in order, pointers wrap with no loss or duplication.
REQ-035 BYPASS=0, DEPTH=2, single push 0x5A at edge N -> valid_output low before N, high with 0x5A after N, data_dest 0 while empty.
REQ-036 Full DEPTH=4, assert rst mid-cycle -> ready_output=1, valid_output=0 (valid=0), level=0 immediately, no clock edge needed.
REQ-037 Full, ready=1 and valid=1 same cycle -> one pop, no push, ready_output high next cycle, count=3.
